// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: bundles the redirect, instruction-SRAM and ID-side
// handshake signals of the decoupled fetch queue. The fetch queue itself
// uses the master view. The surrounding pipeline, SRAM and testbench use
// the slave view.
interface inst_fetch_queue_if;
    // Redirect from ID (branch/jump).
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Synchronous instruction SRAM, one-cycle read latency.
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    // {pc,inst} stream towards ID.
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata,
        output out_valid,
        output out_pc,
        output out_inst,
        input  out_ready
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata,
        input  out_valid,
        input  out_pc,
        input  out_inst,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decoupled IF stage. It issues sequential fetches to a
// synchronous instruction SRAM with one-cycle read latency. It buffers the
// returned {pc,inst} pairs in a DEPTH-entry FIFO and hands them to ID under
// valid/ready backpressure.
// A redirect flushes the FIFO, drops the in-flight response and restarts
// fetch at the redirect address in the same cycle.
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a response that
// arrives while the FIFO is empty is presented to ID in the same cycle. When
// it is not defined, every response passes through the FIFO first.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                   clk,
    input  logic                   reset,
    inst_fetch_queue_if.master     io_ifq
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    // Architectural state.
    logic [31:0]      r_fetch_pc;
    logic             r_req_pending;
    logic [31:0]      r_req_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_inst [DEPTH];

    // Combinational control.
    logic             w_redirect;
    logic [31:0]      w_redirect_addr;
    logic             w_resp_valid;
    logic             w_fifo_valid;
    logic             w_bypass;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_fifo_pop;
    logic             w_push;
    logic [CNT_W:0]   w_occupancy;
    logic             w_issue;
    logic [31:0]      w_fetch_addr;
    logic [31:0]      w_out_pc;
    logic [31:0]      w_out_inst;
    logic             w_unused_pc_lsb;

    // The low address bits of a redirect are always forced to zero.
    assign w_unused_pc_lsb = &{1'b0, io_ifq.redirect_pc[1:0]};

    assign w_redirect      = io_ifq.redirect_valid;
    assign w_redirect_addr = {io_ifq.redirect_pc[31:2], 2'b00};

    // A response is only useful if no redirect kills it on arrival.
    assign w_resp_valid = r_req_pending & ~w_redirect;
    assign w_fifo_valid = (r_count != '0);

`ifdef IFQ_BYPASS_EN
    // An empty FIFO lets the arriving response go straight to ID.
    assign w_bypass   = ~w_fifo_valid & w_resp_valid;
    assign w_out_pc   = w_bypass ? r_req_pc               : r_mem_pc[r_rd_ptr];
    assign w_out_inst = w_bypass ? io_ifq.inst_sram_rdata : r_mem_inst[r_rd_ptr];
`else
    assign w_bypass   = 1'b0;
    assign w_out_pc   = r_mem_pc[r_rd_ptr];
    assign w_out_inst = r_mem_inst[r_rd_ptr];
`endif

    assign w_out_valid = ~reset & (w_fifo_valid | w_bypass);
    assign w_pop       = w_out_valid & io_ifq.out_ready;

    // A bypassed entry never enters the FIFO if ID takes it at once.
    assign w_fifo_pop = w_pop & ~w_bypass;
    assign w_push     = w_resp_valid & ~(w_bypass & io_ifq.out_ready);

    // Credit check: the entries held, plus the one in flight, minus the one
    // leaving this cycle, must leave room for the new request's response.
    assign w_occupancy = {1'b0, r_count}
                       + {{CNT_W{1'b0}}, r_req_pending}
                       - {{CNT_W{1'b0}}, w_pop};
    assign w_issue      = ~reset & (w_redirect | (w_occupancy < DEPTH_OCC));
    assign w_fetch_addr = w_redirect ? w_redirect_addr : r_fetch_pc;

    assign io_ifq.inst_sram_en   = w_issue;
    assign io_ifq.inst_sram_addr = w_fetch_addr;
    assign io_ifq.out_valid      = w_out_valid;
    assign io_ifq.out_pc         = w_out_pc;
    assign io_ifq.out_inst       = w_out_inst;

    // Fetch address and in-flight request tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pending <= 1'b0;
            r_req_pc      <= RESET_PC;
        end else if (w_issue) begin
            r_fetch_pc    <= w_fetch_addr + 32'd4;
            r_req_pending <= 1'b1;
            r_req_pc      <= w_fetch_addr;
        end else begin
            r_req_pending <= 1'b0;
        end
    end

    // FIFO pointers and occupancy. A redirect empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count
                     + {{(CNT_W-1){1'b0}}, w_push}
                     - {{(CNT_W-1){1'b0}}, w_fifo_pop};
        end
    end

    // FIFO storage. It needs no reset because the count qualifies every read.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
            r_mem_inst[r_wr_ptr] <= io_ifq.inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed bench for inst_fetch_queue (DEPTH=4).
// The stimulus block drives reset, out_ready and redirects cycle by cycle.
// It checks fetch addresses and out_valid at fixed cycles. The expected
// {pc,inst} stream is loaded into a scoreboard queue up front. A separate
// monitor pops and compares on every handshake.
// The expectations follow IFQ_BYPASS_EN when that macro is defined.
module tb_inst_fetch_queue;

    logic clk = 1'b0;
    logic reset;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] expPc [$];

    always #5 clk = ~clk;

    inst_fetch_queue_if ifqBus();

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h1c000000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_ifq (ifqBus)
    );

    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    // Instruction SRAM model: the data for an address appears one cycle
    // after the request. Idle cycles return a poison word.
    always @(posedge clk) begin
        if (ifqBus.inst_sram_en)
            ifqBus.inst_sram_rdata <= instOf(ifqBus.inst_sram_addr);
        else
            ifqBus.inst_sram_rdata <= 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset                 = rst;
        ifqBus.out_ready      = rdy;
        ifqBus.redirect_valid = rv;
        ifqBus.redirect_pc    = rpc;
        @(negedge clk);
    endtask

    task automatic pushRun(input logic [31:0] startPc, input int n);
        for (int i = 0; i < n; i++)
            expPc.push_back(startPc + 32'(4 * i));
    endtask

    // Scoreboard monitor: every accepted output must be the next expected pc.
    always @(negedge clk) begin
        if (ifqBus.out_valid === 1'b1 && ifqBus.out_ready === 1'b1) begin
            if (expPc.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL sb_extra_pop actual=%h expected=none", ifqBus.out_pc);
            end else begin
                logic [31:0] e;
                e = expPc.pop_front();
                checkOutput("sb_pc", ifqBus.out_pc, e);
                checkOutput("sb_inst", ifqBus.out_inst, instOf(e));
            end
        end
    end

    initial begin
        reset                 = 1'b1;
        ifqBus.out_ready      = 1'b1;
        ifqBus.redirect_valid = 1'b0;
        ifqBus.redirect_pc    = 32'h0;

`ifdef IFQ_BYPASS_EN
        pushRun(32'h1c000000, 5);
`else
        pushRun(32'h1c000000, 4);
`endif
        pushRun(32'h1c000000, 1);
        pushRun(32'h1c000100, 1);
        pushRun(32'h1c000104, 1);
`ifdef IFQ_BYPASS_EN
        pushRun(32'h1c000000, 4);
`else
        pushRun(32'h1c000000, 3);
`endif

        // Reset held: nothing is fetched or presented.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_en", ifqBus.inst_sram_en, 32'd0);
        checkOutput("rst_valid", ifqBus.out_valid, 32'd0);

        // Sequential fetch after reset release with out_ready=1.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_en", ifqBus.inst_sram_en, 32'd1);
        checkOutput("t1_addr0", ifqBus.inst_sram_addr, 32'h1c000000);
        checkOutput("t1_valid_c0", ifqBus.out_valid, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_addr1", ifqBus.inst_sram_addr, 32'h1c000004);
`ifdef IFQ_BYPASS_EN
        checkOutput("t6_valid_c1", ifqBus.out_valid, 32'd1);
        checkOutput("t6_pc_c1", ifqBus.out_pc, 32'h1c000000);
`else
        checkOutput("t1_valid_c1", ifqBus.out_valid, 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_addr2", ifqBus.inst_sram_addr, 32'h1c000008);
        checkOutput("t1_valid_c2", ifqBus.out_valid, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_addr3", ifqBus.inst_sram_addr, 32'h1c00000c);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // A one-cycle reset, then fill the queue with out_ready=0.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_rst_en", ifqBus.inst_sram_en, 32'd0);
        checkOutput("t2_rst_valid", ifqBus.out_valid, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_addr0", ifqBus.inst_sram_addr, 32'h1c000000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_en_4th", ifqBus.inst_sram_en, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_en_stop", ifqBus.inst_sram_en, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_en_held", ifqBus.inst_sram_en, 32'd0);
        checkOutput("t2_valid_full", ifqBus.out_valid, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_en_held2", ifqBus.inst_sram_en, 32'd0);
        checkOutput("t2_head", ifqBus.out_pc, 32'h1c000000);

        // First pop lets fetch resume in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_resume_en", ifqBus.inst_sram_en, 32'd1);
        checkOutput("t2_resume_addr", ifqBus.inst_sram_addr, 32'h1c000010);

        // Redirect with count=3 and a request in flight; unaligned target.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000103);
        checkOutput("t3_en", ifqBus.inst_sram_en, 32'd1);
        checkOutput("t3_addr", ifqBus.inst_sram_addr, 32'h1c000100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IFQ_BYPASS_EN
        checkOutput("t3_valid_next", ifqBus.out_valid, 32'd1);
        checkOutput("t3_bypass_pc", ifqBus.out_pc, 32'h1c000100);
`else
        checkOutput("t3_valid_next", ifqBus.out_valid, 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_valid", ifqBus.out_valid, 32'd1);
        checkOutput("t3_first_pc", ifqBus.out_pc, 32'h1c000100);

        // Redirect in the same cycle as a pop: the head leaves exactly once.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1c000200);
        checkOutput("t4_head", ifqBus.out_pc, 32'h1c000104);
        checkOutput("t4_addr", ifqBus.inst_sram_addr, 32'h1c000200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IFQ_BYPASS_EN
        checkOutput("t4_after_pc", ifqBus.out_pc, 32'h1c000200);
`else
        checkOutput("t4_empty", ifqBus.out_valid, 32'd0);
`endif

        // Fill to full, then a one-cycle reset.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_full_valid", ifqBus.out_valid, 32'd1);
        checkOutput("t5_full_en", ifqBus.inst_sram_en, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_rst_valid", ifqBus.out_valid, 32'd0);
        checkOutput("t5_rst_en", ifqBus.inst_sram_en, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_addr", ifqBus.inst_sram_addr, 32'h1c000000);
        checkOutput("t5_no_stale", ifqBus.out_valid, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef IFQ_BYPASS_EN
        checkOutput("t6_valid_t1", ifqBus.out_valid, 32'd1);
`else
        checkOutput("t6_valid_t1", ifqBus.out_valid, 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // Quiesce and confirm every expected entry was delivered.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("sb_drained", 32'(expPc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
